sorted_search: RTL

SORTED_SEARCH -- requirements
Module: sorted_search

---
 rtl/sorted_search.sv | 115 +++++++++++
 1 files changed

// File: rtl/sorted_search.sv
// Purpose: binary search of a signed key over a DEPTH-entry ascending table held in registers.
// Latency: result valid exactly r_steps edges after query acceptance (1..log2(DEPTH)+1).
// Backpressure: one query in flight; result held until r_ready, writes while busy are dropped.
// Ports: clock/reset_n; wr_en/wr_addr/wr_data table write, wr_drop flags a discarded write;
//        q_valid/q_ready/q_key query handshake; r_valid/r_ready result handshake with
//        r_found, r_index (hit index or insertion point) and r_steps (compares used).
module sorted_search #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  output logic                    wr_drop,
  input  logic                    q_valid,
  output logic                    q_ready,
  input  logic signed [WIDTH-1:0] q_key,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic                    r_found,
  output logic [AW:0]             r_index,
  output logic [AW:0]             r_steps
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  // Two extra bits on the bounds so hi can reach -1 and lo can reach DEPTH.
  localparam logic signed [AW+1:0] ONE  = (AW+2)'(1);
  localparam logic signed [AW+1:0] LAST = (AW+2)'(DEPTH - 1);

  state_t                  state, state_nxt;
  logic signed [WIDTH-1:0] mem [DEPTH];
  logic signed [WIDTH-1:0] key;
  logic signed [AW+1:0]    lo, hi, lo_nxt, hi_nxt, mid_s;
  logic [AW-1:0]           mid;
  logic                    hit, less, miss;

  // One compare per SEARCH cycle; the bounds are non-negative while searching,
  // so an unsigned floor halving of their sum is the midpoint.
  always_comb begin
    mid    = AW'(($unsigned(lo) + $unsigned(hi)) >> 1);
    mid_s  = $signed({2'b00, mid});
    hit    = (mem[mid] == key);
    less   = (mem[mid] < key);
    lo_nxt = lo;
    hi_nxt = hi;
    if (!hit) begin
      if (less) lo_nxt = mid_s + ONE;
      else      hi_nxt = mid_s - ONE;
    end
    miss = !hit && (lo_nxt > hi_nxt);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (q_valid)     state_nxt = SEARCH;
      SEARCH:  if (hit || miss) state_nxt = DONE;
      DONE:    if (r_ready)     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  assign q_ready = (state == IDLE);
  assign r_valid = (state == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      key     <= '0;
      lo      <= '0;
      hi      <= '0;
      r_steps <= '0;
      r_found <= 1'b0;
      r_index <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && (state != IDLE);
      // A write landing on the acceptance edge is visible to the first compare.
      if (wr_en && state == IDLE) mem[wr_addr] <= wr_data;
      case (state)
        IDLE: begin
          if (q_valid) begin
            key     <= q_key;
            lo      <= '0;
            hi      <= LAST;
            r_steps <= '0;
          end
        end
        SEARCH: begin
          r_steps <= r_steps + (AW+1)'(1);
          lo      <= lo_nxt;
          hi      <= hi_nxt;
          if (hit) begin
            r_found <= 1'b1;
            r_index <= {1'b0, mid};
          end else if (miss) begin
            r_found <= 1'b0;
            r_index <= lo_nxt[AW:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
